// File: rtl/mem_fill_responder_pkg.sv
// Shared constants for the line-fill responder.
//
// Contents:
//   WORD_W      - data/address word width in bits
//   BYTE_OFF_W  - byte-offset bits inside one 32-bit word
//   LAT_W       - width of the latency down-counter (LATENCY <= 255)
//   state_t     - FSM state encoding: StIdle, StWait, StSend
//   line_base() - clears the byte offset of a line from an address
package mem_fill_responder_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BYTE_OFF_W = 2;
    localparam int unsigned LAT_W      = 8;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StWait = 2'd1;
    localparam state_t StSend = 2'd2;

    // Clear the low off_w bits so the result is aligned to the start of a line.
    function automatic logic [WORD_W-1:0] line_base(input logic [WORD_W-1:0] addr,
                                                    input int unsigned       off_w);
        logic [WORD_W-1:0] mask;
        mask = '1;
        mask = mask << off_w;
        return addr & mask;
    endfunction

endpackage

// File: rtl/mem_fill_responder_if.sv
// Request/response bus between a cache (master) and the line-fill responder (slave).
//
// Signals:
//   req_valid  master->slave  cache presents a line-fill request
//   req_ready  slave->master  responder can accept a request
//   req_addr   master->slave  byte address of the missing access
//   rsp_valid  slave->master  rsp_data holds a valid beat
//   rsp_ready  master->slave  cache accepts the current beat
//   rsp_data   slave->master  fill data word
//   rsp_last   slave->master  final beat of the line
interface mem_fill_responder_if;
    import mem_fill_responder_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [WORD_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_data;
    logic              rsp_last;

    modport master (
        output req_valid,
        output req_addr,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_last
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_last
    );

endinterface

// File: rtl/mem_fill_responder.sv
// Line-fill responder: accepts a cache line-fill request, waits LATENCY cycles and
// then streams BEATS words whose values are the word addresses of the line.
//
// Parameters:
//   LATENCY  wait cycles between acceptance and first beat (0..255)
//   BEATS    32-bit words per line (power of two, 1..16)
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   bus         slave side of mem_fill_responder_if (request and response channels)
//   fill_count  number of completed line fills, wraps modulo 2^32
module mem_fill_responder
    import mem_fill_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned BEATS   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_fill_responder_if.slave  bus,
    output logic [WORD_W-1:0]    fill_count
);

    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W  = $clog2(BEATS) + BYTE_OFF_W;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    // Counter runs LATENCY-1 .. 0, the exit edge supplies the final wait cycle.
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

    if (LATENCY > 255) begin : g_bad_latency
        $error("mem_fill_responder: LATENCY must be 0..255");
    end
    if (BEATS < 1 || BEATS > 16 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_beats
        $error("mem_fill_responder: BEATS must be a power of two in 1..16");
    end

    state_t              state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WORD_W-1:0]   base_q, base_d;
    logic [WORD_W-1:0]   fill_count_q, fill_count_d;
    logic [WORD_W-1:0]   beat_off;

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        beat_d       = beat_q;
        base_d       = base_q;
        fill_count_d = fill_count_q;

        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    base_d = line_base(bus.req_addr, OFF_W);
                    beat_d = '0;
                    if (LATENCY == 0) begin
                        state_d = StSend;
                    end else begin
                        state_d = StWait;
                        lat_d   = LAT_LOAD;
                    end
                end
            end
            StWait: begin
                if (lat_q == '0) begin
                    state_d = StSend;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            StSend: begin
                if (bus.rsp_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        // Return to idle; req_ready only rises after this edge.
                        state_d      = StIdle;
                        beat_d       = '0;
                        fill_count_d = fill_count_q + WORD_W'(1);
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            lat_q        <= '0;
            beat_q       <= '0;
            base_q       <= '0;
            fill_count_q <= '0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
            fill_count_q <= fill_count_d;
        end
    end

    // Outputs decode registered state only, so data/last hold while stalled.
    always_comb begin
        beat_off                 = '0;
        beat_off[BEAT_W+1:0]     = {beat_q, 2'b00};

        bus.req_ready = (state_q == StIdle);
        bus.rsp_valid = (state_q == StSend);
        bus.rsp_last  = (state_q == StSend) && (beat_q == LAST_BEAT);
        // Base is line aligned, so the add wraps modulo 2^32 naturally.
        bus.rsp_data  = (state_q == StSend) ? (base_q + beat_off) : '0;
    end

    assign fill_count = fill_count_q;

endmodule

// File: tb/tb_mem_fill_responder.sv
module tb_mem_fill_responder;
    import mem_fill_responder_pkg::*;

    localparam int unsigned LAT0   = 4;
    localparam int unsigned BEATS0 = 4;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fc0, fc1;

    always #5 clk = ~clk;

    mem_fill_responder_if a_if();
    mem_fill_responder_if b_if();

    mem_fill_responder #(.LATENCY(LAT0), .BEATS(BEATS0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .bus        (a_if.slave),
        .fill_count (fc0)
    );

    mem_fill_responder #(.LATENCY(0), .BEATS(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .bus        (b_if.slave),
        .fill_count (fc1)
    );

    int          checks = 0;
    int          errors = 0;

    beat_t       exp_q[$];
    bit          busy = 0;
    bit          armed = 0;
    int          edges = 0;
    int          acc_cnt = 0;
    int          beat_cnt = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    bit          rdy_toggle = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // rsp_ready driver: held high, or pattern 1,0,0 repeating.
    initial begin
        int phase = 0;
        a_if.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rdy_toggle) a_if.rsp_ready = 1'b1;
            else             a_if.rsp_ready = ((phase % 3) == 0);
            phase++;
        end
    end

    // Monitor / scoreboard for dut0, sampling on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            if (armed) edges++;
            @(negedge clk);
            if (!reset) begin
                if (prev_stall) begin
                    check_eq("stall_valid", a_if.rsp_valid, 1);
                    check_eq("stall_data", a_if.rsp_data, prev_data);
                    check_eq("stall_last", a_if.rsp_last, prev_last);
                end
                if (!a_if.rsp_valid) check_eq("idle_data", a_if.rsp_data, 0);
                check_eq("req_ready", a_if.req_ready, busy ? 0 : 1);
                if (armed && a_if.rsp_valid) begin
                    check_eq("latency", edges, LAT0 + 1);
                    armed = 0;
                end
                if (a_if.rsp_valid && a_if.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_beat", a_if.rsp_valid, 0);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check_eq("rsp_data", a_if.rsp_data, e.data);
                        check_eq("rsp_last", a_if.rsp_last, e.last);
                        beat_cnt++;
                        if (e.last) busy = 0;
                    end
                end
                prev_stall = a_if.rsp_valid && !a_if.rsp_ready;
                prev_data  = a_if.rsp_data;
                prev_last  = a_if.rsp_last;
                if (a_if.req_valid && a_if.req_ready) begin
                    logic [31:0] base;
                    base = a_if.req_addr & ~(32'(BEATS0 * 4) - 32'd1);
                    for (int i = 0; i < int'(BEATS0); i++) begin
                        exp_q.push_back('{data: base + 32'(4 * i), last: (i == int'(BEATS0) - 1)});
                    end
                    busy  = 1;
                    armed = 1;
                    edges = 0;
                    acc_cnt++;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] addr);
        int a0;
        a0 = acc_cnt;
        a_if.req_valid = 1'b1;
        a_if.req_addr  = addr;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != a0) break;
        end
        a_if.req_valid = 1'b0;
        check_eq("accepted", acc_cnt - a0, 1);
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) done = 1;
        end
        check_eq({tag, "_drained"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        int b0, a0;
        reset          = 1'b1;
        a_if.req_valid = 1'b0;
        a_if.req_addr  = '0;
        b_if.req_valid = 1'b0;
        b_if.req_addr  = '0;
        b_if.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req_ready", a_if.req_ready, 1);
        check_eq("rst_rsp_valid", a_if.rsp_valid, 0);
        check_eq("rst_rsp_last", a_if.rsp_last, 0);
        check_eq("rst_rsp_data", a_if.rsp_data, 0);
        check_eq("rst_fill_count", fc0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single fill, rsp_ready held high.
        b0 = beat_cnt;
        issue(32'h0000_1234);
        drain("t1");
        check_eq("t1_beats", beat_cnt - b0, 4);
        check_eq("t1_fill_count", fc0, 1);

        // Toggling rsp_ready.
        rdy_toggle = 1;
        b0 = beat_cnt;
        issue(32'h0000_0040);
        drain("t2");
        check_eq("t2_beats", beat_cnt - b0, 4);
        check_eq("t2_fill_count", fc0, 2);
        rdy_toggle = 0;

        // Back-to-back with req_valid held.
        a0 = acc_cnt;
        a_if.req_valid = 1'b1;
        a_if.req_addr  = 32'h0000_0080;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt == a0 + 1) a_if.req_addr = 32'h0000_0200;
            if (acc_cnt == a0 + 2) break;
        end
        a_if.req_valid = 1'b0;
        drain("t3");
        check_eq("t3_accepts", acc_cnt - a0, 2);
        check_eq("t3_fill_count", fc0, 4);

        // Reset during the second beat.
        b0 = beat_cnt;
        a_if.req_valid = 1'b1;
        a_if.req_addr  = 32'h0000_0300;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != 0 && busy) a_if.req_valid = 1'b0;
            if (beat_cnt == b0 + 1) break;
        end
        a_if.req_valid = 1'b0;
        check_eq("t4_in_second_beat", a_if.rsp_valid, 1);
        reset = 1'b1;
        #1;
        check_eq("t4_rst_valid", a_if.rsp_valid, 0);
        check_eq("t4_rst_data", a_if.rsp_data, 0);
        check_eq("t4_rst_fill_count", fc0, 0);
        exp_q.delete();
        busy       = 0;
        armed      = 0;
        prev_stall = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        b0 = beat_cnt;
        issue(32'h0000_0100);
        drain("t4");
        check_eq("t4_beats", beat_cnt - b0, 4);
        check_eq("t4_fill_count", fc0, 1);

        // Fill counter wrap.
        dut0.fill_count_q = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        issue(32'h0000_0500);
        drain("t5a");
        check_eq("t5_count_max", fc0, 32'hFFFF_FFFF);
        issue(32'h0000_0600);
        drain("t5b");
        check_eq("t5_count_wrap", fc0, 32'h0000_0000);

        // LATENCY=0, BEATS=1 instance.
        b_if.req_valid = 1'b1;
        b_if.req_addr  = 32'hFFFF_FFFF;
        @(negedge clk);
        check_eq("t6_req_ready", b_if.req_ready, 1);
        @(posedge clk);
        #1;
        b_if.req_valid = 1'b0;
        @(negedge clk);
        check_eq("t6_valid", b_if.rsp_valid, 1);
        check_eq("t6_data", b_if.rsp_data, 32'hFFFF_FFFC);
        check_eq("t6_last", b_if.rsp_last, 1);
        check_eq("t6_ready_busy", b_if.req_ready, 0);
        @(posedge clk);
        #1;
        check_eq("t6_valid_after", b_if.rsp_valid, 0);
        check_eq("t6_fill_count", fc1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_fill_responder.md
MEM_FILL_RESPONDER -- requirements
Module: mem_fill_responder

Interface
REQ-001 Parameter LATENCY, default 4, SHALL be the wait cycles between request acceptance and the first response beat; legal range 0..255.
REQ-002 Parameter BEATS, default 4, SHALL be the 32-bit words per cache line; power of two, 1..16.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 req_valid  input  1  SHALL indicate that the cache presents a line-fill request.
REQ-006 req_ready  output  1  SHALL indicate that the responder can accept a request.
REQ-007 req_addr  input  32  SHALL be the byte address of the missing access.
REQ-008 rsp_valid  output  1  SHALL indicate that rsp_data holds a valid beat.
REQ-009 rsp_ready  input  1  SHALL indicate that the cache accepts the current beat.
REQ-010 rsp_data  output  32  SHALL be the fill data word.
REQ-011 rsp_last  output  1  SHALL mark the final beat of a line.
REQ-012 fill_count  output  32  SHALL count completed line fills.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and SEND.
REQ-014 In IDLE, req_ready SHALL be 1; in WAIT and SEND it SHALL be 0.
REQ-015 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1; the responder SHALL then latch line base = req_addr with bits [log2(BEATS)+1:0] cleared.
REQ-016 On acceptance with LATENCY>0, the FSM SHALL enter WAIT and load a down-counter with LATENCY-1; with LATENCY=0 it SHALL enter SEND directly.
REQ-017 WAIT SHALL decrement the counter each cycle and move to SEND on the edge where the counter equals 0.
REQ-018 The first rsp_valid=1 SHALL appear exactly LATENCY+1 edges after the acceptance edge.
REQ-019 In SEND, rsp_valid SHALL be 1, and rsp_data SHALL be line base + 4*beat, beat = 0..BEATS-1.
REQ-020 rsp_last SHALL be 1 only when beat = BEATS-1.
REQ-021 A beat SHALL advance only on an edge with rsp_valid=1 and rsp_ready=1.
REQ-022 While rsp_ready=0, rsp_data and rsp_last SHALL remain stable.
REQ-023 On the handshake of the last beat, the FSM SHALL return to IDLE, and fill_count SHALL increment by 1, wrapping from 0xFFFFFFFF to 0.
REQ-024 A new request SHALL NOT be accepted on the same edge as the last-beat handshake; req_ready SHALL rise on the following cycle.
REQ-025 req_valid and req_addr SHALL be ignored outside IDLE.
REQ-026 Line base arithmetic SHALL wrap modulo 2^32.
REQ-027 rsp_data SHALL be 0 whenever rsp_valid=0.

Reset
REQ-028 Asserting reset SHALL immediately force these values:
- FSM = IDLE
- req_ready = 1
- rsp_valid = 0
- rsp_last = 0
- rsp_data = 0
- fill_count = 0
- beat and latency counters = 0
REQ-029 Reset asserted mid-fill SHALL abort the fill without incrementing fill_count; after reset release, the first accepted request SHALL behave as from power-up.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration, the 32-bit word width constant and the byte-offset width constant.
REQ-031 The responder SHALL be a single module with no sub-modules; the beat and latency counters SHALL live inline.

Verification
REQ-032 Defaults, request 0x00001234 with rsp_ready held at 1:
- first beat 5 edges after acceptance
- data 0x00001230, 0x00001234, 0x00001238, 0x0000123C
- rsp_last set on the 4th beat
- fill_count = 1
REQ-033 Request 0x00000040 with rsp_ready toggling 1,0,0,1,…:
- each beat holds stable while stalled
- exactly 4 beats delivered, no duplicates or skips
REQ-034 LATENCY=0, BEATS=1, request 0xFFFFFFFF:
- one beat, data 0xFFFFFFFC, rsp_last=1, one edge after acceptance
REQ-035 Back-to-back requests with req_valid held at 1:
- req_ready low during the fill
- second acceptance no earlier than one cycle after the first fill's last beat
- fill_count = 2
REQ-036 Reset asserted during the 2nd beat of a fill:
- rsp_valid = 0 immediately
- fill_count = 0
- next request 0x00000100 returns 0x00000100..0x0000010C with correct latency
REQ-037 Preload fill_count near wrap and complete two fills:
- count goes 0xFFFFFFFF then 0x00000000
